// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer: opcode map, FSM states
// and the default datapath width.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_RSVD6 = 3'd6;
  localparam logic [2:0] OP_RSVD7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_seq: registered output, full/empty flags, no
// same-cycle bypass, so a push into an empty FIFO is visible one cycle later.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Accumulator sequencer driving an external combinational ALU.
// Optional command FIFO enabled by defining ALU_SEQ_FIFO_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = ALU_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_n,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [3:0]        alu_cc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_cc,
  output logic              res_err,
  output logic              busy
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_seq: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] imm_q;
  logic [3:0]        flags_q;
  logic [2:0]        op_q;
  logic              err_q;
  logic              op_rsvd;

  logic              in_valid;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_imm;
  logic              take;

`ifdef ALU_SEQ_FIFO_EN
  logic [DATA_W+2:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  alu_cmd_fifo #(
    .WIDTH (DATA_W + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_op, cmd_imm}),
    .pop   (take),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready         = !fifo_full && !rst;
  assign in_valid          = !fifo_empty;
  assign {in_op, in_imm}   = fifo_dout;
`else
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign in_valid  = cmd_valid;
  assign in_op     = cmd_op;
  assign in_imm    = cmd_imm;
`endif

  assign op_rsvd = (op_q == OP_RSVD6) || (op_q == OP_RSVD7);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    alu_a   = acc_q;
    alu_b   = '0;
    alu_n   = OP_PASSA;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_b   = imm_q;
        alu_n   = op_rsvd ? OP_PASSA : op_q;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      flags_q <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Clear lands on the same edge as acceptance, so the op sees A=0.
          if (acc_clr) begin
            acc_q   <= '0;
            flags_q <= '0;
          end
          if (take) begin
            op_q  <= in_op;
            imm_q <= in_imm;
          end
        end
        ISSUE: begin
          if (op_rsvd) begin
            err_q <= 1'b1;
          end else begin
            err_q   <= 1'b0;
            acc_q   <= alu_r;
            flags_q <= alu_cc;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state_q == RESP);
  assign res_data  = acc_q;
  assign res_cc    = flags_q;
  assign res_err   = res_valid && err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural ALU attached.
module tb_alu_seq;

  localparam int unsigned DW = 8;
`ifdef ALU_SEQ_FIFO_EN
  localparam int LAT         = 3;
  localparam int STALL_READY = 1;
`else
  localparam int LAT         = 2;
  localparam int STALL_READY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic          acc_clr = 1'b0;
  logic [DW-1:0] alu_a, alu_b, alu_r;
  logic [2:0]    alu_n;
  logic [3:0]    alu_cc;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic [3:0]    res_cc;
  logic          res_err;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .acc_clr   (acc_clr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_n     (alu_n),
    .alu_r     (alu_r),
    .alu_cc    (alu_cc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cc    (res_cc),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Flags are {N, Z, C, V}; C is carry-out / borrow / shifted-out bit.
  logic [DW:0] alu_tmp;
  always_comb begin
    alu_tmp = '0;
    case (alu_n)
      3'd0:    alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1:    alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2:    alu_tmp = {alu_a, 1'b0};
      3'd3:    alu_tmp = {alu_a[0], 1'b0, alu_a[DW-1:1]};
      3'd4:    alu_tmp = {1'b0, alu_a};
      3'd5:    alu_tmp = {1'b0, alu_b};
      default: alu_tmp = '0;
    endcase
    alu_r  = alu_tmp[DW-1:0];
    alu_cc = {alu_tmp[DW-1], alu_tmp[DW-1:0] == '0, alu_tmp[DW], 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] imm, input logic clr);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    acc_clr   = clr;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_clr   = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [DW-1:0] d, input logic e,
                             input logic [3:0] cc, input logic chk_cc, input int lat_exp);
    int n = 1;
    @(negedge clk);
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 32'(res_valid), 32'd1);
    if (lat_exp > 0) check({tag, ".latency"}, 32'(n), 32'(lat_exp));
    check({tag, ".data"}, 32'(res_data), 32'(d));
    check({tag, ".err"}, 32'(res_err), 32'(e));
    if (chk_cc) check({tag, ".cc"}, 32'(res_cc), 32'(cc));
    if (res_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.res_valid", 32'(res_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.res_err", 32'(res_err), 32'd0);
    check("rst.res_data", 32'(res_data), 32'h00);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;

    send(3'd4, 8'h00, 1'b0);
    expect_resp("passa0", 8'h00, 1'b0, 4'b0100, 1'b1, LAT);

    send(3'd5, 8'h10, 1'b0);
    expect_resp("passb", 8'h10, 1'b0, 4'b0000, 1'b1, LAT);
    send(3'd0, 8'h05, 1'b0);
    expect_resp("add", 8'h15, 1'b0, 4'b0000, 1'b1, LAT);
    send(3'd1, 8'h20, 1'b0);
    expect_resp("sub_wrap", 8'hF5, 1'b0, 4'b1010, 1'b1, LAT);
    send(3'd2, 8'h5A, 1'b0);
    expect_resp("shl", 8'hEA, 1'b0, 4'b1010, 1'b1, LAT);
    send(3'd3, 8'hA5, 1'b0);
    expect_resp("shr", 8'h75, 1'b0, 4'b0000, 1'b1, LAT);

    // Reserved opcode leaves acc and flags alone
    send(3'd5, 8'h15, 1'b0);
    expect_resp("set15", 8'h15, 1'b0, 4'b0000, 1'b1, LAT);
    send(3'd6, 8'hAA, 1'b0);
    expect_resp("rsvd6", 8'h15, 1'b1, 4'b0000, 1'b1, LAT);
    send(3'd4, 8'h00, 1'b0);
    expect_resp("after_rsvd", 8'h15, 1'b0, 4'b0000, 1'b1, LAT);

    // Held response with acc_clr during RESP, which must be ignored
    res_ready = 1'b0;
    send(3'd0, 8'h01, 1'b0);
    expect_resp("stall", 8'h16, 1'b0, 4'b0000, 1'b0, LAT);
    acc_clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.valid_hold", 32'(res_valid), 32'd1);
      check("stall.data_hold", 32'(res_data), 32'h16);
      check("stall.cmd_ready", 32'(cmd_ready), 32'(STALL_READY));
    end
    acc_clr   = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall.busy_after", 32'(busy), 32'd0);
    send(3'd4, 8'h00, 1'b0);
    expect_resp("clr_in_resp_ignored", 8'h16, 1'b0, 4'b0000, 1'b0, LAT);

    // acc_clr coincident with acceptance
    send(3'd0, 8'h03, 1'b1);
    expect_resp("clr_accept", 8'h03, 1'b0, 4'b0000, 1'b1, LAT);
    @(negedge clk);
    check("idle.alu_a", 32'(alu_a), 32'h03);
    check("idle.alu_b", 32'(alu_b), 32'h00);
    check("idle.alu_n", 32'(alu_n), 32'd4);

    // Reset while the command is in ISSUE
    send(3'd0, 8'h22, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 10);
    check("rst_mid.reached_issue", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid.cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    check("rst_mid.no_resp", 32'(seen), 32'd0);
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.acc", 32'(alu_a), 32'h00);
    send(3'd0, 8'h01, 1'b0);
    expect_resp("after_rst", 8'h01, 1'b0, 4'b0000, 1'b1, LAT);

`ifdef ALU_SEQ_FIFO_EN
    // FSM parked in RESP so nothing pops; four pushes fill the FIFO
    res_ready = 1'b0;
    send(3'd4, 8'h00, 1'b0);
    expect_resp("fifo.head", 8'h01, 1'b0, 4'b0000, 1'b0, LAT);
    for (int i = 0; i < 4; i++) send(3'd0, 8'h01, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_imm   = 8'h01;
    #1;
    check("fifo.full_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    expect_resp("fifo.q0", 8'h02, 1'b0, 4'b0000, 1'b0, -1);
    expect_resp("fifo.q1", 8'h03, 1'b0, 4'b0000, 1'b0, -1);
    expect_resp("fifo.q2", 8'h04, 1'b0, 4'b0000, 1'b0, -1);
    expect_resp("fifo.q3", 8'h05, 1'b0, 4'b0000, 1'b0, -1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    check("fifo.fifth_dropped", 32'(seen), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
